protocol_framer: RTL and testbench
==================================

# protocol_framer

Transmit-side counterpart of `protocol_parser`. It builds a response frame (header, command, length, payload, checksum) and feeds it byte-by-byte into the `uart` transmitter's `tx_data_in`/`tx_start`/`tx_busy` port. It sits between `command_processor` (frame requester) and `u_uart`. Payload bytes are fetched from an external synchronous-read buffer through a read port that mirrors the parser's payload port.

## Interface
- `MAX_PAYLOAD_LEN`, 256, largest accepted payload length in bytes.
- `PAYLOAD_ADDR_WIDTH`, `$clog2(MAX_PAYLOAD_LEN)`, payload buffer address width.

- `clk`  in  1  system clock.
- `rst_n`  in  1  reset. Asynchronous assertion, active-low.
- `send_start`  in  1  single-cycle request. Sampled only in IDLE.
- `cmd_in`  in  8  command byte. Latched with `send_start`.
- `len_in`  in  16  payload length. Latched with `send_start`.
- `payload_read_addr`  out  PAYLOAD_ADDR_WIDTH  payload buffer address.
- `payload_read_data`  in  8  buffer data. Valid one cycle after the address is presented.
- `tx_data_out`  out  8  byte to the UART transmitter.
- `tx_start`  out  1  one-cycle strobe to the UART transmitter.
- `tx_busy`  in  1  UART transmitter busy flag.
- `busy`  out  1  high from the accepted request until `done`.
- `done`  out  1  one-cycle pulse after the last byte has left the UART.
- `error`  out  1  one-cycle pulse when `len_in > MAX_PAYLOAD_LEN`.

## Operation
- Frame byte order: `0xAA`, `0x55`, CMD, LEN[15:8], LEN[7:0], payload[0..LEN-1], CSUM.
- CSUM is the 8-bit sum, modulo 256, of CMD, LEN_H, LEN_L and all payload bytes. Header bytes are excluded.
- FSM states:
  - IDLE. On `send_start`:
    - If `len_in > MAX_PAYLOAD_LEN`, pulse `error`, stay in IDLE, emit no bytes.
    - Otherwise latch `cmd_in`/`len_in`, clear the checksum, set `busy`, set the field to HDR0, and go to FETCH.
  - FETCH. Select the byte for the current field. For the PAYLOAD field, drive `payload_read_addr` = byte index, then go to FETCH_WAIT for one cycle.
  - LOAD. Register the selected byte into `tx_data_out`. For CMD, LEN and PAYLOAD fields, also add the byte to the checksum.
  - START. Wait until `tx_busy`=0, then pulse `tx_start` for one cycle.
  - WAIT_ACK. Wait for `tx_busy`=1.
  - WAIT_IDLE. Wait for `tx_busy`=0. Then advance the field/index and return to FETCH. If this was the last byte, go to FINISH.
  - FINISH. Pulse `done`, clear `busy`, return to IDLE.
- A length of 0 skips the PAYLOAD field entirely; LEN_L is followed directly by CSUM.
- The payload index counts 0..LEN-1 and is PAYLOAD_ADDR_WIDTH+1 bits wide, so LEN = MAX_PAYLOAD_LEN does not wrap before the compare.
- `send_start` while `busy`=1 is ignored; it is neither queued nor an error.
- `cmd_in`/`len_in` changes after acceptance have no effect on the frame in progress.

## Timing
- Reset values: `tx_start`=0, `tx_data_out`=0x00, `payload_read_addr`=0, `busy`=0, `done`=0, `error`=0. FSM enters IDLE.
- Reset mid-frame aborts immediately. No further `tx_start`. A byte already inside the UART completes on its own.
- `send_start` at cycle N gives `busy`=1 at N+1. The first `tx_start` is at N+4 or later (FETCH, LOAD, START), gated by `tx_busy`=0.
- Payload byte: address at cycle M, data captured at M+2 (FETCH_WAIT, then LOAD).
- `tx_data_out` is stable from the LOAD cycle until the next LOAD.
- `error` is asserted at N+1 and lasts exactly one cycle.
- `done` is asserted one cycle after `tx_busy` falls for the final byte. `busy` deasserts in the same cycle as `done`.
- `busy` and `error` are never high together. `done` and `error` are never high together.
- If `tx_busy` never rises after `tx_start`, the block stays in WAIT_ACK until reset. No timeout.

## Configuration
- Macro: `PROTOCOL_FRAMER_CHECKSUM_EN`.
- Defined: the CSUM byte is appended, as described in Operation.
- Undefined: the frame ends after the last payload byte (after LEN_L when LEN=0), and the checksum logic is removed. Total frame length becomes 5+LEN bytes instead of 6+LEN.

## Test plan
- CMD=0x01, LEN=0 -> UART bytes `AA 55 01 00 00 01`, then a single `done` pulse.
- CMD=0x05, LEN=2, payload `10 20` -> bytes `AA 55 05 00 02 10 20 37`. `payload_read_addr` visits 0 then 1.
- CMD=0x02, LEN=2, payload `FF FF` -> CSUM = 0x02 (checksum wrap-around).
- LEN=257 -> `error` pulse at N+1, zero `tx_start` strobes, `busy` stays 0. A following valid request is then framed normally.
- `send_start` pulsed again mid-frame with CMD=0x09 -> ignored; the original frame completes unaltered and exactly one `done` pulse occurs.
- `rst_n` low during the payload phase -> all outputs return to reset values within the reset assertion and no `tx_start` follows. With the macro undefined, CMD=0x05, LEN=2 gives `AA 55 05 00 02 10 20` (7 bytes).

Source files
------------

// File: rtl/protocol_framer.sv
// Response frame builder feeding a UART transmitter: AA 55 CMD LEN_H LEN_L payload [CSUM].
// Define PROTOCOL_FRAMER_CHECKSUM_EN to append the trailing checksum byte.
module protocol_framer #(
    parameter int MAX_PAYLOAD_LEN    = 256,
    parameter int PAYLOAD_ADDR_WIDTH = $clog2(MAX_PAYLOAD_LEN)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          send_start,
    input  logic [7:0]                    cmd_in,
    input  logic [15:0]                   len_in,
    output logic [PAYLOAD_ADDR_WIDTH-1:0] payload_read_addr,
    input  logic [7:0]                    payload_read_data,
    output logic [7:0]                    tx_data_out,
    output logic                          tx_start,
    input  logic                          tx_busy,
    output logic                          busy,
    output logic                          done,
    output logic                          error
);

    localparam int          IDX_W   = PAYLOAD_ADDR_WIDTH + 1;
    localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD_LEN);

    typedef enum logic [2:0] {
        IDLE, FETCH, FETCH_WAIT, LOAD, START, WAIT_ACK, WAIT_IDLE, FINISH
    } state_t;

    typedef enum logic [2:0] {
        HDR0, HDR1, CMD, LEN_H, LEN_L, PAYLOAD, CSUM
    } field_t;

    state_t           state;
    state_t           next_state;
    field_t           field;
    logic [IDX_W-1:0] index;
    logic [7:0]       cmd_latched;
    logic [15:0]      len_latched;
    logic [7:0]       sel_byte;
    logic             accept;
    logic             reject;
    logic             payload_end;
    logic             last_byte;
    logic             byte_sent;
`ifdef PROTOCOL_FRAMER_CHECKSUM_EN
    logic [7:0]       csum;
`endif

    assign accept      = (state == IDLE) && send_start && (len_in <= MAX_LEN);
    assign reject      = (state == IDLE) && send_start && (len_in > MAX_LEN);
    assign payload_end = (16'(index) + 16'd1) == len_latched;
    assign byte_sent   = (state == WAIT_IDLE) && !tx_busy;

`ifdef PROTOCOL_FRAMER_CHECKSUM_EN
    assign last_byte = (field == CSUM);
`else
    assign last_byte = ((field == LEN_L) && (len_latched == 16'd0)) ||
                       ((field == PAYLOAD) && payload_end);
`endif

    always_comb begin
        sel_byte = 8'h00;
        case (field)
            HDR0:    sel_byte = 8'hAA;
            HDR1:    sel_byte = 8'h55;
            CMD:     sel_byte = cmd_latched;
            LEN_H:   sel_byte = len_latched[15:8];
            LEN_L:   sel_byte = len_latched[7:0];
            PAYLOAD: sel_byte = payload_read_data;
`ifdef PROTOCOL_FRAMER_CHECKSUM_EN
            CSUM:    sel_byte = csum;
`endif
            default: sel_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:       if (accept) next_state = FETCH;
            FETCH:      next_state = (field == PAYLOAD) ? FETCH_WAIT : LOAD;
            FETCH_WAIT: next_state = LOAD;
            LOAD:       next_state = START;
            START:      if (!tx_busy) next_state = WAIT_ACK;
            WAIT_ACK:   if (tx_busy) next_state = WAIT_IDLE;
            WAIT_IDLE:  if (!tx_busy) next_state = last_byte ? FINISH : FETCH;
            FINISH:     next_state = IDLE;
            default:    next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE) && (state != FINISH);
        done = (state == FINISH);
    end

    // The payload address is registered in FETCH so the synchronous buffer has its data ready by LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            field             <= HDR0;
            index             <= '0;
            cmd_latched       <= 8'h00;
            len_latched       <= 16'h0000;
            tx_data_out       <= 8'h00;
            tx_start          <= 1'b0;
            payload_read_addr <= '0;
            error             <= 1'b0;
`ifdef PROTOCOL_FRAMER_CHECKSUM_EN
            csum              <= 8'h00;
`endif
        end else begin
            tx_start <= (state == START) && !tx_busy;
            error    <= reject;
            if (accept) begin
                cmd_latched <= cmd_in;
                len_latched <= len_in;
                field       <= HDR0;
                index       <= '0;
`ifdef PROTOCOL_FRAMER_CHECKSUM_EN
                csum        <= 8'h00;
`endif
            end
            if ((state == FETCH) && (field == PAYLOAD))
                payload_read_addr <= index[PAYLOAD_ADDR_WIDTH-1:0];
            if (state == LOAD) begin
                tx_data_out <= sel_byte;
`ifdef PROTOCOL_FRAMER_CHECKSUM_EN
                if ((field == CMD) || (field == LEN_H) || (field == LEN_L) || (field == PAYLOAD))
                    csum <= csum + sel_byte;
`endif
            end
            if (byte_sent && !last_byte) begin
                case (field)
                    HDR0:    field <= HDR1;
                    HDR1:    field <= CMD;
                    CMD:     field <= LEN_H;
                    LEN_H:   field <= LEN_L;
                    LEN_L:   field <= (len_latched == 16'd0) ? CSUM : PAYLOAD;
                    PAYLOAD: begin
                        if (payload_end) field <= CSUM;
                        else             index <= index + IDX_W'(1);
                    end
                    default: field <= HDR0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_protocol_framer.sv
// Randomized bench for protocol_framer: a frame-level model predicts every UART byte, busy, done and error.
// Honours PROTOCOL_FRAMER_CHECKSUM_EN the same way the design does.
module tb_protocol_framer;

    localparam int MAX_LEN = 256;
    localparam int AW      = 8;
`ifdef PROTOCOL_FRAMER_CHECKSUM_EN
    localparam int CSUM_BYTES = 1;
`else
    localparam int CSUM_BYTES = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          send_start = 1'b0;
    logic [7:0]    cmd_in = 8'h00;
    logic [15:0]   len_in = 16'h0000;
    logic [AW-1:0] payload_read_addr;
    logic [7:0]    payload_read_data = 8'h00;
    logic [7:0]    tx_data_out;
    logic          tx_start;
    logic          tx_busy = 1'b0;
    logic          busy;
    logic          done;
    logic          error;

    protocol_framer #(.MAX_PAYLOAD_LEN(MAX_LEN), .PAYLOAD_ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .send_start(send_start), .cmd_in(cmd_in), .len_in(len_in),
        .payload_read_addr(payload_read_addr), .payload_read_data(payload_read_data),
        .tx_data_out(tx_data_out), .tx_start(tx_start), .tx_busy(tx_busy),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] mem [MAX_LEN];
    logic [7:0] exp_q [$];
    logic [7:0] rx_log [$];
    int         done_count = 0;
    int         error_count = 0;
    int         start_count = 0;
    bit         m_idle = 1'b1;
    bit         m_busy = 1'b0;
    bit         m_active = 1'b0;
    bit         exp_done = 1'b0;
    bit         exp_error = 1'b0;
    bit         fell = 1'b0;
    int         u_phase = 0;
    int         u_delay = 0;
    int         u_len = 0;
    logic [AW-1:0] ram_addr = '0;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Whole frame predicted from the request and the buffer contents at acceptance time.
    task automatic build_frame(input logic [7:0] cmd, input logic [15:0] len);
`ifdef PROTOCOL_FRAMER_CHECKSUM_EN
        logic [7:0] sum;
`endif
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h55);
        exp_q.push_back(cmd);
        exp_q.push_back(len[15:8]);
        exp_q.push_back(len[7:0]);
        for (int i = 0; i < int'(len); i++) exp_q.push_back(mem[i]);
`ifdef PROTOCOL_FRAMER_CHECKSUM_EN
        sum = cmd + len[15:8] + len[7:0];
        for (int i = 0; i < int'(len); i++) sum = sum + mem[i];
        exp_q.push_back(sum);
`endif
    endtask

    task automatic check_bytes(input string name, input logic [63:0] lit_with_csum, input int n_with_csum);
        logic [63:0] lit;
        int          n;
        lit = lit_with_csum >> (8 * (1 - CSUM_BYTES));
        n   = n_with_csum - (1 - CSUM_BYTES);
        check_output({name, "_count"}, rx_log.size(), n);
        for (int i = 0; i < n && i < rx_log.size(); i++)
            check_output($sformatf("%s_byte%0d", name, i), 32'(rx_log[i]), 32'(lit[8*(n-1-i) +: 8]));
    endtask

    task automatic apply_stimulus(input logic [7:0] cmd, input logic [15:0] len);
        @(posedge clk); #2;
        send_start = 1'b1;
        cmd_in     = cmd;
        len_in     = len;
        @(posedge clk); #2;
        send_start = 1'b0;
        cmd_in     = 8'($urandom);
        len_in     = 16'($urandom);
    endtask

    task automatic wait_frame(input string name);
        int start = done_count;
        int n = 0;
        while (done_count == start && n < 8000) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        check_output({name, "_done_pulses"}, done_count - start, 1);
    endtask

    task automatic randomize_mem();
        for (int i = 0; i < MAX_LEN; i++) mem[i] = 8'($urandom);
    endtask

    task automatic check_reset_values(input string name);
        check_output({name, "_tx_start"}, 32'(tx_start), 0);
        check_output({name, "_tx_data"}, 32'(tx_data_out), 0);
        check_output({name, "_addr"}, 32'(payload_read_addr), 0);
        check_output({name, "_busy"}, 32'(busy), 0);
        check_output({name, "_done"}, 32'(done), 0);
        check_output({name, "_error"}, 32'(error), 0);
    endtask

    // Synchronous-read payload buffer: address seen before an edge, data valid just after it.
    initial begin
        forever begin
            @(negedge clk);
            ram_addr = payload_read_addr;
            @(posedge clk);
            #1 payload_read_data = mem[ram_addr];
        end
    end

    // Compare process plus UART transmitter model, evaluated once per cycle on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check_reset_values("in_reset");
                exp_q.delete();
                m_idle    = 1'b1;
                m_busy    = 1'b0;
                m_active  = 1'b0;
                exp_done  = 1'b0;
                exp_error = 1'b0;
            end else begin
                check_output("error", 32'(error), 32'(exp_error));
                check_output("done", 32'(done), 32'(exp_done));
                check_output("busy", 32'(busy), 32'(m_busy));
                check_output("busy_error_excl", 32'(busy & error), 0);
                if (done) done_count++;
                if (error) error_count++;
                if (tx_start) begin
                    start_count++;
                    check_output("tx_start_while_uart_busy", 32'((u_phase != 0) || tx_busy), 0);
                    if (exp_q.size() == 0) check_output("unexpected_tx_start", 32'(tx_data_out) | 32'h100, 0);
                    else check_output("tx_byte", 32'(tx_data_out), 32'(exp_q.pop_front()));
                    rx_log.push_back(tx_data_out);
                end
                exp_error = m_idle && send_start && (len_in > 16'd256);
                if (m_idle && send_start && (len_in <= 16'd256)) begin
                    build_frame(cmd_in, len_in);
                    m_idle   = 1'b0;
                    m_busy   = 1'b1;
                    m_active = 1'b1;
                end
                if (exp_done) m_idle = 1'b1;
            end
            fell = 1'b0;
            if (tx_start) begin
                u_phase = 1;
                u_delay = $urandom_range(0, 2);
                u_len   = $urandom_range(1, 4);
            end
            if (u_phase == 1) begin
                if (u_delay == 0) begin
                    tx_busy = 1'b1;
                    u_phase = 2;
                end else u_delay--;
            end else if (u_phase == 2) begin
                u_len--;
                if (u_len == 0) begin
                    tx_busy = 1'b0;
                    u_phase = 0;
                    fell    = 1'b1;
                end
            end
            exp_done = rst_n && fell && m_active && (exp_q.size() == 0);
            if (exp_done) begin
                m_busy   = 1'b0;
                m_active = 1'b0;
            end
        end
    end

    initial begin
        #950000;
        $display("[TB] FAIL watchdog: time budget exhausted, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

    initial begin : main
        int          e0;
        int          s0;
        int          n;
        int          r;
        logic [15:0] len;
        randomize_mem();
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset_values("reset");
        @(posedge clk); #2 rst_n = 1'b1;

        rx_log.delete();
        apply_stimulus(8'h01, 16'd0);
        wait_frame("len0");
        check_bytes("len0", 64'h00_AA_55_01_00_00_01, 6);

        mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'h99;
        rx_log.delete();
        apply_stimulus(8'h05, 16'd2);
        wait_frame("len2");
        check_bytes("len2", 64'hAA_55_05_00_02_10_20_37, 8);

        mem[0] = 8'hFF; mem[1] = 8'hFF;
        rx_log.delete();
        apply_stimulus(8'h02, 16'd2);
        wait_frame("wrap");
        check_bytes("wrap", 64'hAA_55_02_00_02_FF_FF_02, 8);

        e0 = error_count; s0 = start_count;
        apply_stimulus(8'h07, 16'd257);
        repeat (4) @(posedge clk);
        check_output("len257_error_pulses", error_count - e0, 1);
        check_output("len257_tx_starts", start_count - s0, 0);
        mem[0] = 8'h22;
        rx_log.delete();
        apply_stimulus(8'h11, 16'd1);
        wait_frame("after_error");
        check_bytes("after_error", 64'h00_AA_55_11_00_01_22_34, 7);

        mem[0] = 8'h40;
        rx_log.delete();
        apply_stimulus(8'h03, 16'd1);
        repeat (6) @(posedge clk);
        apply_stimulus(8'h09, 16'd1);
        wait_frame("ignored_req");
        check_bytes("ignored_req", 64'h00_AA_55_03_00_01_40_44, 7);
        s0 = start_count;
        repeat (30) @(posedge clk);
        check_output("no_queued_frame", start_count - s0, 0);

        randomize_mem();
        rx_log.delete();
        apply_stimulus(8'hC3, 16'd256);
        wait_frame("len256");
        check_output("len256_count", rx_log.size(), 261 + CSUM_BYTES);
        if (rx_log.size() >= 261) begin
            check_output("len256_first_payload", 32'(rx_log[5]), 32'(mem[0]));
            check_output("len256_last_payload", 32'(rx_log[260]), 32'(mem[255]));
        end

        randomize_mem();
        rx_log.delete();
        apply_stimulus(8'h0C, 16'd20);
        n = 0;
        while (rx_log.size() < 8 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check_output("reach_payload_phase", 32'(rx_log.size() >= 8), 1);
        @(posedge clk); #2 rst_n = 1'b0;
        #1 check_reset_values("abort");
        s0 = start_count;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        check_output("abort_no_tx_start", start_count - s0, 0);
        n = 0;
        while ((u_phase != 0 || tx_busy) && n < 100) begin
            @(posedge clk);
            n++;
        end
        mem[0] = 8'h10; mem[1] = 8'h20;
        rx_log.delete();
        apply_stimulus(8'h05, 16'd2);
        wait_frame("after_abort");
        check_bytes("after_abort", 64'hAA_55_05_00_02_10_20_37, 8);

        for (int it = 0; it < 14; it++) begin
            randomize_mem();
            r = $urandom_range(0, 9);
            case (r)
                0:       len = 16'd0;
                1:       len = 16'd255;
                2:       len = 16'($urandom_range(257, 65535));
                default: len = 16'($urandom_range(1, 16));
            endcase
            rx_log.delete();
            e0 = error_count;
            apply_stimulus(8'($urandom), len);
            if (len > 16'd256) begin
                repeat (4) @(posedge clk);
                check_output("rand_reject_error", error_count - e0, 1);
                check_output("rand_reject_bytes", rx_log.size(), 0);
            end else begin
                if (r == 3) begin
                    repeat (4) @(posedge clk);
                    apply_stimulus(8'($urandom), 16'($urandom_range(0, 300)));
                end
                wait_frame("rand");
                check_output("rand_frame_len", rx_log.size(), int'(len) + 5 + CSUM_BYTES);
            end
        end

        repeat (5) @(posedge clk);
        check_output("model_queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
